// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, idle-high line. The input passes through a 2-flop synchronizer.
// Each bit is sampled at its centre, and each received byte is presented with a one-cycle strobe.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy,
  output logic [2:0] dbg_state_o
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t       state_q;
  logic [1:0]   sync_q;
  logic [CW-1:0] clk_cnt_q;
  logic [2:0]   bit_idx_q;
  logic [7:0]   shift_q;
  logic [7:0]   data_q;
  logic         valid_q;
  logic         ferr_q;
  logic         rx_s;

  assign rx_s        = sync_q[1];
  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign frame_err   = ferr_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sync_q    <= 2'b11;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_in};
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            clk_cnt_q <= '0;
            state_q   <= START;
          end
        end
        START: begin
          // A start bit that is no longer low at its centre is treated as line noise.
          if (clk_cnt_q == CW'(HALF - 1)) begin
            if (!rx_s) begin
              clk_cnt_q <= '0;
              bit_idx_q <= '0;
              state_q   <= DATA;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (clk_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
            shift_q[bit_idx_q] <= rx_s;
            clk_cnt_q          <= '0;
            if (bit_idx_q == 3'd7) state_q <= STOP;
            else                   bit_idx_q <= bit_idx_q + 3'd1;
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        STOP: begin
          // Re-arm at the centre of the stop bit so a following start edge is not missed.
          if (clk_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
            clk_cnt_q <= '0;
            if (rx_s) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= BREAK;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        BREAK: begin
          if (rx_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: stimulus frames at 16 clk/bit, a scoreboard of expected bytes,
// and strobe counters checked after each scenario.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int dv_cnt   = 0;
  int fe_cnt   = 0;
  int dv_base;
  int fe_base;
  logic prev_strobe = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_in       (rx_in),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_err   (frame_err),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid || frame_err) begin
        check("strobe_exclusive", {31'd0, data_valid & frame_err}, 32'd0);
        check("strobe_width", {31'd0, prev_strobe}, 32'd0);
      end
      if (data_valid) begin
        dv_cnt++;
        if (exp_q.size() == 0) check("unexpected_dv", 32'd1, 32'd0);
        else                   check("rx_data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
      end
      if (frame_err) fe_cnt++;
    end
    prev_strobe = data_valid | frame_err;
  end

  // Drivers
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    wait_clks(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      drive_bit(b[i]);
      if (i == 0) check("busy_mid_frame", {31'd0, busy}, 32'd1);
    end
    drive_bit(stop_bit);
  endtask

  task automatic mark;
    dv_base = dv_cnt;
    fe_base = fe_cnt;
  endtask

  initial begin
    rst_n = 1'b0;
    rx_in = 1'b1;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(50);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_data", {24'd0, data_out}, 32'h00);
    check("reset_state", {29'd0, dbg_state}, 32'd0);
    check("reset_no_dv", dv_cnt, 0);
    check("reset_no_fe", fe_cnt, 0);

    // Single good frame
    mark();
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    wait_clks(20);
    check("a5_dv_count", dv_cnt - dv_base, 1);
    check("a5_fe_count", fe_cnt - fe_base, 0);
    check("a5_data", {24'd0, data_out}, 32'hA5);
    check("a5_busy_idle", {31'd0, busy}, 32'd0);

    // Start-bit glitch
    mark();
    rx_in = 1'b0;
    wait_clks(4);
    rx_in = 1'b1;
    wait_clks(40);
    check("glitch_dv", dv_cnt - dv_base, 0);
    check("glitch_fe", fe_cnt - fe_base, 0);
    check("glitch_busy", {31'd0, busy}, 32'd0);
    check("glitch_data", {24'd0, data_out}, 32'hA5);

    // Framing error then recovery
    mark();
    send_byte(8'h3C, 1'b0);
    rx_in = 1'b1;
    wait_clks(32);
    check("ferr_fe_count", fe_cnt - fe_base, 1);
    check("ferr_dv_count", dv_cnt - dv_base, 0);
    check("ferr_data_kept", {24'd0, data_out}, 32'hA5);
    check("ferr_busy_idle", {31'd0, busy}, 32'd0);
    mark();
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1);
    wait_clks(20);
    check("after_ferr_dv", dv_cnt - dv_base, 1);
    check("after_ferr_data", {24'd0, data_out}, 32'h55);

    // Back-to-back frames, no idle gap
    mark();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    wait_clks(20);
    check("b2b_dv_count", dv_cnt - dv_base, 2);
    check("b2b_fe_count", fe_cnt - fe_base, 0);
    check("b2b_data", {24'd0, data_out}, 32'hFF);

    // Line break: 40 bit times low
    mark();
    rx_in = 1'b0;
    wait_clks(40 * CPB);
    check("break_busy", {31'd0, busy}, 32'd1);
    rx_in = 1'b1;
    wait_clks(40);
    check("break_fe_count", fe_cnt - fe_base, 1);
    check("break_dv_count", dv_cnt - dv_base, 0);
    check("break_busy_idle", {31'd0, busy}, 32'd0);

    // Reset in the middle of data bit 4
    mark();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b0 : 1'b1);
    rx_in = 1'b0;
    wait_clks(CPB / 2);
    rst_n = 1'b0;
    rx_in = 1'b1;
    #1;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_data", {24'd0, data_out}, 32'h00);
    wait_clks(2);
    rst_n = 1'b1;
    wait_clks(40);
    check("midreset_dv", dv_cnt - dv_base, 0);
    check("midreset_fe", fe_cnt - fe_base, 0);
    mark();
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    wait_clks(20);
    check("post_reset_dv", dv_cnt - dv_base, 1);
    check("post_reset_data", {24'd0, data_out}, 32'h81);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
